div: RTL and testbench

Multi-cycle radix-2 divider that serves the execute stage for DIV and DIVU. It accepts operands and a start request from the execute stage and runs a restoring shift-subtract sequence of one quotient bit per clock. It then presents the 64-bit {remainder, quotient} result with a ready flag, which the execute stage forwards to HI/LO. While the divider is busy, the execute stage holds its stall request to the pipeline controller. The execute stage raises annul when the pipeline flushes the divide.

---
 rtl/div_if.sv | 28 ++
 rtl/div.sv | 140 ++++++++++++++
 tb/tb_div.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// div_if: execute-stage <-> divider handshake bundle.
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       divide request, held by the execute stage until ready_o
//   annul_i       abort the divide in progress (pipeline flush)
//   result_o      {remainder, quotient}, nonzero only while ready_o = 1
//   ready_o       result valid
// master = execute stage, slave = divider.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  div_if slave modport (operands, start/annul in; result/ready out)
// One quotient bit per clock on magnitudes; signs are re-applied in the
// final ON cycle. Ready rises 33 edges after the start edge, or after the
// second state transition (FREE -> BYZERO -> END) for a zero divisor.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, produce a zero result
// ON     | shift-subtract in progress, cnt_q counts completed steps
// END    | result valid, waiting for start_i to drop
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [64:0] work_q,     work_d;
    logic [31:0] divisor_q,  divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q,  neg_rem_d;
    logic [63:0] result_q,   result_d;
    logic        ready_q,    ready_d;

    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [64:0] shifted;
    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign op1_mag = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1)
                                                            : bus.opdata1_i;
    assign op2_mag = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1)
                                                            : bus.opdata2_i;

    // work_q = {partial remainder[32:0], remaining dividend / quotient bits[31:0]}.
    // The partial remainder stays below 2*divisor, so a 33-bit difference
    // never overflows and its top bit is a reliable borrow.
    assign shifted  = {work_q[63:0], 1'b0};
    assign diff     = shifted[64:32] - {1'b0, divisor_q};
    assign quot_fix = neg_quot_q ? (~work_q[31:0]  + 32'd1) : work_q[31:0];
    assign rem_fix  = neg_rem_q  ? (~work_q[63:32] + 32'd1) : work_q[63:32];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    neg_quot_d = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                    neg_rem_d  = bus.signed_div_i && bus.opdata1_i[31];
                    divisor_d  = op2_mag;
                    work_d     = {33'd0, op1_mag};
                    cnt_d      = 6'd0;
                    state_d    = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = END;
            end
            ON: begin
                if (bus.annul_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = FREE;
                end else if (cnt_q == 6'd32) begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    state_d  = END;
                end else begin
                    if (diff[32]) begin
                        work_d = shifted;
                    end else begin
                        work_d = {diff, shifted[31:1], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = FREE;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb_div: directed-vector bench for div. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_div;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_if bus ();

    div u_div (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a divide and wait for ready. n = index of the edge after which
    // ready was seen (start edge is E0); leak flags a nonzero result before ready.
    task automatic issue_and_wait(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output int n, output logic leak);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        @(posedge clk);
        #1;
        // operands must no longer matter once sampled
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = 32'h0000_0000;
        bus.signed_div_i = ~sgn;
        n    = 0;
        leak = 1'b0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.ready_o) break;
            if (bus.result_o != 64'd0) leak = 1'b1;
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int   n;
        logic leak;
        issue_and_wait(sgn, a, b, n, leak);
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, bus.result_o, exp);
        chk({tag, " early result"}, 64'(leak), 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " ready clear"}, 64'(bus.ready_o), 64'd0);
        chk({tag, " result clear"}, bus.result_o, 64'd0);
    endtask

    initial begin
        int   n;
        logic leak;
        logic seen;

        errors = 0;
        checks = 0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(bus.ready_o), 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu 7/2",        1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33);
        run_div("div -7/2",        1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("div 7/-2",        1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        run_div("div -7/-2",       1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33);
        run_div("div min/-1",      1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_div("divu max/1",      1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33);
        run_div("divu 8000/ffff",  1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
        run_div("divu max/10000",  1'b0, 32'hFFFFFFFF, 32'h00010000, 64'h0000FFFF_0000FFFF, 33);

        // zero divisor: FREE -> BYZERO at the start edge, -> END at the next;
        // then start held with annul raised must leave END untouched
        issue_and_wait(1'b1, 32'd5, 32'd0, n, leak);
        chk("div 5/0 latency", 64'(n), 64'd1);
        chk("div 5/0 result", bus.result_o, 64'd0);
        chk("div 5/0 ready", 64'(bus.ready_o), 64'd1);
        @(negedge clk);
        bus.annul_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("end hold ready", 64'(bus.ready_o), 64'd1);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("div 5/0 ready clear", 64'(bus.ready_o), 64'd0);

        // annul in ON: no ready pulse, then a fresh divide runs normally
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul ready", 64'(bus.ready_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen = 1'b1;
        end
        chk("annul no ready", 64'(seen), 64'd0);
        run_div("divu 100/3", 1'b0, 32'd100, 32'd3, 64'h00000001_00000021, 33);

        // async reset during ON
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst in ON ready", 64'(bus.ready_o), 64'd0);
        chk("rst in ON result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;

        // async reset while the result is presented, checked before any edge
        issue_and_wait(1'b0, 32'd1000, 32'd7, n, leak);
        chk("divu 1000/7 result", bus.result_o, 64'h00000006_0000008E);
        #1;
        rst = 1'b1;
        #1;
        chk("rst in END ready", 64'(bus.ready_o), 64'd0);
        chk("rst in END result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b0;

        run_div("post-rst 1000/7", 1'b0, 32'd1000, 32'd7, 64'h00000006_0000008E, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
